// File: rtl/fft_ram_pkg.sv
// Shared types and helpers for the FFT sample memory controller.
package fft_ram_pkg;

    typedef enum logic [1:0] {
        RAM_LOAD,
        RAM_RUN,
        RAM_UNLOAD
    } ram_state;

    localparam int unsigned BITREV_W = 16;
    localparam logic [15:0] IM_ZERO  = 16'h0000;

    // Reverse the low log2n bits of index; bits above log2n come out as zero.
    function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] index,
                                                   input logic [4:0]          log2n);
        logic [BITREV_W-1:0] rev;
        rev = {<<{index}};
        return rev >> (5'(BITREV_W) - log2n);
    endfunction

endpackage

// File: rtl/sample_mem.sv
// Single-port synchronous RAM with two registered read captures sharing the one address port.
module sample_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en_a,
    input  logic                  rd_en_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array has no reset so contents survive i_rstn.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (rd_en_a) begin
                rdata_a <= mem[addr];
            end
            if (rd_en_b) begin
                rdata_b <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/fft_sample_ram.sv
// Sample memory ownership controller: bridge loads bit-reversed, core computes, bridge unloads natural order.
module fft_sample_ram
    import fft_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [15:0]           i_SAMPLE_ram,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLE_INDEX_ram,
    input  logic                  i_WRITE_ram,
    input  logic                  i_READ_ram,
    input  logic                  i_DATA_LOADED,
    input  logic [3:0]            i_LOG2N,
    output logic [DATA_WIDTH-1:0] o_DATA_FROM_RAM,
    output logic                  o_CALC_END,
    output logic [ADDR_WIDTH-1:0] o_SAMPLES_NUMBER,
    output logic                  o_START,
    input  logic [ADDR_WIDTH-1:0] i_CORE_ADDR,
    input  logic                  i_CORE_WE,
    input  logic [DATA_WIDTH-1:0] i_CORE_WDATA,
    output logic [DATA_WIDTH-1:0] o_CORE_RDATA,
    input  logic                  i_CORE_DONE,
    output logic                  o_OVERRUN
);

    ram_state state;

    logic [4:0]            log2n_c;
    logic [ADDR_WIDTH-1:0] n_m1_c;
    logic                  overrun_c;
    logic [ADDR_WIDTH-1:0] load_addr_c;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rd_bridge;
    logic                  mem_rd_core;

    // Clamp the size exponent into 1..ADDR_WIDTH and derive N-1, range check and load address.
    always_comb begin
        if (i_LOG2N == 4'd0) begin
            log2n_c = 5'd1;
        end else if ({1'b0, i_LOG2N} > 5'(ADDR_WIDTH)) begin
            log2n_c = 5'(ADDR_WIDTH);
        end else begin
            log2n_c = {1'b0, i_LOG2N};
        end
        n_m1_c      = ~({ADDR_WIDTH{1'b1}} << log2n_c);
        overrun_c   = (i_SAMPLE_INDEX_ram >> log2n_c) != '0;
        load_addr_c = ADDR_WIDTH'(bitrev(BITREV_W'(i_SAMPLE_INDEX_ram), log2n_c));
    end

    // Memory port mux follows the current owner.
    always_comb begin
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_rd_bridge = 1'b0;
        mem_rd_core   = 1'b0;
        case (state)
            RAM_LOAD: begin
                if (i_WRITE_ram && !overrun_c) begin
                    mem_we    = 1'b1;
                    mem_addr  = load_addr_c;
                    mem_wdata = DATA_WIDTH'({i_SAMPLE_ram, IM_ZERO});
                end
            end
            RAM_RUN: begin
                mem_we      = i_CORE_WE;
                mem_addr    = i_CORE_ADDR;
                mem_wdata   = i_CORE_WDATA;
                mem_rd_core = 1'b1;
            end
            RAM_UNLOAD: begin
                if (i_READ_ram) begin
                    mem_addr      = i_SAMPLE_INDEX_ram;
                    mem_rd_bridge = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Ownership FSM with registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state            <= RAM_LOAD;
            o_START          <= 1'b0;
            o_CALC_END       <= 1'b0;
            o_OVERRUN        <= 1'b0;
            o_SAMPLES_NUMBER <= '0;
        end else begin
            o_START <= 1'b0;
            case (state)
                RAM_LOAD: begin
                    if (i_WRITE_ram && overrun_c) begin
                        o_OVERRUN <= 1'b1;
                    end
                    if (i_DATA_LOADED) begin
                        o_SAMPLES_NUMBER <= n_m1_c;
                        o_START          <= 1'b1;
                        state            <= RAM_RUN;
                    end
                end
                RAM_RUN: begin
                    if (i_CORE_DONE) begin
                        o_CALC_END <= 1'b1;
                        state      <= RAM_UNLOAD;
                    end
                end
                RAM_UNLOAD: begin
                    if (i_READ_ram && (i_SAMPLE_INDEX_ram == o_SAMPLES_NUMBER)) begin
                        o_CALC_END <= 1'b0;
                        o_OVERRUN  <= 1'b0;
                        state      <= RAM_LOAD;
                    end
                end
                default: state <= RAM_LOAD;
            endcase
        end
    end

    sample_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .rd_en_a (mem_rd_bridge),
        .rd_en_b (mem_rd_core),
        .rdata_a (o_DATA_FROM_RAM),
        .rdata_b (o_CORE_RDATA)
    );

endmodule

// File: tb/tb_fft_sample_ram.sv
// Directed self-checking bench for fft_sample_ram.
module tb_fft_sample_ram;

    logic        i_clk;
    logic        i_rstn;
    logic [15:0] i_SAMPLE_ram;
    logic [11:0] i_SAMPLE_INDEX_ram;
    logic        i_WRITE_ram;
    logic        i_READ_ram;
    logic        i_DATA_LOADED;
    logic [3:0]  i_LOG2N;
    logic [31:0] o_DATA_FROM_RAM;
    logic        o_CALC_END;
    logic [11:0] o_SAMPLES_NUMBER;
    logic        o_START;
    logic [11:0] i_CORE_ADDR;
    logic        i_CORE_WE;
    logic [31:0] i_CORE_WDATA;
    logic [31:0] o_CORE_RDATA;
    logic        i_CORE_DONE;
    logic        o_OVERRUN;

    int n_checks = 0;
    int n_errors = 0;

    fft_sample_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_SAMPLE_ram       (i_SAMPLE_ram),
        .i_SAMPLE_INDEX_ram (i_SAMPLE_INDEX_ram),
        .i_WRITE_ram        (i_WRITE_ram),
        .i_READ_ram         (i_READ_ram),
        .i_DATA_LOADED      (i_DATA_LOADED),
        .i_LOG2N            (i_LOG2N),
        .o_DATA_FROM_RAM    (o_DATA_FROM_RAM),
        .o_CALC_END         (o_CALC_END),
        .o_SAMPLES_NUMBER   (o_SAMPLES_NUMBER),
        .o_START            (o_START),
        .i_CORE_ADDR        (i_CORE_ADDR),
        .i_CORE_WE          (i_CORE_WE),
        .i_CORE_WDATA       (i_CORE_WDATA),
        .o_CORE_RDATA       (o_CORE_RDATA),
        .i_CORE_DONE        (i_CORE_DONE),
        .o_OVERRUN          (o_OVERRUN)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bridge_write(input logic [11:0] idx, input logic [15:0] smp, input logic loaded);
        i_SAMPLE_INDEX_ram = idx;
        i_SAMPLE_ram       = smp;
        i_WRITE_ram        = 1'b1;
        i_DATA_LOADED      = loaded;
        tick();
        i_WRITE_ram   = 1'b0;
        i_DATA_LOADED = 1'b0;
    endtask

    task automatic core_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        i_CORE_ADDR = addr;
        tick();
        check(tag, o_CORE_RDATA, exp);
    endtask

    task automatic bridge_read(input logic [11:0] idx);
        i_SAMPLE_INDEX_ram = idx;
        i_READ_ram         = 1'b1;
        tick();
        i_READ_ram = 1'b0;
    endtask

    logic [31:0] exp8 [8];
    logic [31:0] exp4 [4];

    initial begin
        i_rstn = 1'b0;
        i_SAMPLE_ram = '0;
        i_SAMPLE_INDEX_ram = '0;
        i_WRITE_ram = 1'b0;
        i_READ_ram = 1'b0;
        i_DATA_LOADED = 1'b0;
        i_LOG2N = 4'd3;
        i_CORE_ADDR = '0;
        i_CORE_WE = 1'b0;
        i_CORE_WDATA = '0;
        i_CORE_DONE = 1'b0;

        // Addr a holds sample index bitrev3(a); addr 2 is overwritten by the core.
        exp8[0] = 32'h1000_0000; exp8[1] = 32'h1004_0000;
        exp8[2] = 32'hDEAD_BEEF; exp8[3] = 32'h1006_0000;
        exp8[4] = 32'h1001_0000; exp8[5] = 32'h1005_0000;
        exp8[6] = 32'h1003_0000; exp8[7] = 32'h1007_0000;
        exp4[0] = 32'h2000_0000; exp4[1] = 32'h1004_0000;
        exp4[2] = 32'hDEAD_BEEF; exp4[3] = 32'h2003_0000;

        tick();
        check("rst_start", 32'(o_START), 32'd0);
        check("rst_calc_end", 32'(o_CALC_END), 32'd0);
        check("rst_overrun", 32'(o_OVERRUN), 32'd0);
        check("rst_samples", 32'(o_SAMPLES_NUMBER), 32'd0);
        check("rst_bridge_data", o_DATA_FROM_RAM, 32'd0);
        check("rst_core_data", o_CORE_RDATA, 32'd0);
        i_rstn = 1'b1;
        tick();

        // Bit-reverse load, last write coincident with the end-of-load pulse.
        for (int i = 0; i < 7; i++) begin
            bridge_write(12'(i), 16'h1000 + 16'(i), 1'b0);
            check("load_no_start", 32'(o_START), 32'd0);
        end
        bridge_write(12'd7, 16'h1007, 1'b1);
        check("start_pulse", 32'(o_START), 32'd1);
        check("samples_n8", 32'(o_SAMPLES_NUMBER), 32'd7);
        check("core_rdata_idle_load", o_CORE_RDATA, 32'd0);

        i_CORE_ADDR = 12'd1;
        tick();
        check("start_single", 32'(o_START), 32'd0);
        check("core_rd_a1", o_CORE_RDATA, 32'h1004_0000);
        core_read(12'd3, 32'h1006_0000, "core_rd_a3");
        core_read(12'd7, 32'h1007_0000, "core_rd_a7");

        // Bridge strobes during RUN must not touch memory or read data.
        i_SAMPLE_INDEX_ram = 12'd0;
        i_SAMPLE_ram = 16'hAAAA;
        i_WRITE_ram = 1'b1;
        i_READ_ram = 1'b1;
        tick();
        i_WRITE_ram = 1'b0;
        i_READ_ram = 1'b0;
        check("run_bridge_rd_ignored", o_DATA_FROM_RAM, 32'd0);

        i_CORE_ADDR = 12'd2;
        i_CORE_WDATA = 32'hDEAD_BEEF;
        i_CORE_WE = 1'b1;
        tick();
        i_CORE_WE = 1'b0;
        check("calc_end_before_done", 32'(o_CALC_END), 32'd0);
        i_CORE_DONE = 1'b1;
        tick();
        i_CORE_DONE = 1'b0;
        check("calc_end_rise", 32'(o_CALC_END), 32'd1);

        // Core write and end-of-load pulse in UNLOAD are ignored.
        i_CORE_ADDR = 12'd5;
        i_CORE_WDATA = 32'h1234_5678;
        i_CORE_WE = 1'b1;
        i_DATA_LOADED = 1'b1;
        tick();
        i_CORE_WE = 1'b0;
        i_DATA_LOADED = 1'b0;
        check("unload_no_start", 32'(o_START), 32'd0);
        check("unload_calc_end_held", 32'(o_CALC_END), 32'd1);

        for (int i = 0; i < 8; i++) begin
            bridge_read(12'(i));
            check($sformatf("unload8_data_%0d", i), o_DATA_FROM_RAM, exp8[i]);
            check($sformatf("unload8_calc_end_%0d", i), 32'(o_CALC_END), (i == 7) ? 32'd0 : 32'd1);
            check($sformatf("unload8_samples_%0d", i), 32'(o_SAMPLES_NUMBER), 32'd7);
        end
        tick();
        check("bridge_data_held", o_DATA_FROM_RAM, 32'h1007_0000);

        // Overrun: index 5 with N=4 is dropped and flagged.
        i_LOG2N = 4'd2;
        bridge_write(12'd5, 16'h5555, 1'b0);
        check("overrun_set", 32'(o_OVERRUN), 32'd1);
        bridge_write(12'd0, 16'h2000, 1'b0);
        bridge_write(12'd3, 16'h2003, 1'b1);
        check("start_n4", 32'(o_START), 32'd1);
        check("samples_n4", 32'(o_SAMPLES_NUMBER), 32'd3);
        core_read(12'd2, 32'hDEAD_BEEF, "overrun_not_stored_a2");
        core_read(12'd5, 32'h1005_0000, "overrun_not_stored_a5");
        core_read(12'd0, 32'h2000_0000, "run_bridge_wr_ignored_a0");
        check("overrun_held_run", 32'(o_OVERRUN), 32'd1);
        i_CORE_DONE = 1'b1;
        tick();
        i_CORE_DONE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bridge_read(12'(i));
            check($sformatf("unload4_data_%0d", i), o_DATA_FROM_RAM, exp4[i]);
            check($sformatf("unload4_overrun_%0d", i), 32'(o_OVERRUN), (i == 3) ? 32'd0 : 32'd1);
        end
        check("unload4_calc_end_fall", 32'(o_CALC_END), 32'd0);

        // LOG2N=0 acts as 1; reset mid-RUN with outputs active.
        i_LOG2N = 4'd0;
        bridge_write(12'd2, 16'h7777, 1'b0);
        bridge_write(12'd1, 16'h3001, 1'b1);
        check("samples_log2n0", 32'(o_SAMPLES_NUMBER), 32'd1);
        core_read(12'd1, 32'h3001_0000, "core_rd_log2n0_a1");
        core_read(12'd0, 32'h2000_0000, "overrun_log2n0_not_stored");
        check("overrun_pre_reset", 32'(o_OVERRUN), 32'd1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("mid_rst_start", 32'(o_START), 32'd0);
        check("mid_rst_calc_end", 32'(o_CALC_END), 32'd0);
        check("mid_rst_overrun", 32'(o_OVERRUN), 32'd0);
        check("mid_rst_samples", 32'(o_SAMPLES_NUMBER), 32'd0);
        check("mid_rst_bridge_data", o_DATA_FROM_RAM, 32'd0);
        check("mid_rst_core_data", o_CORE_RDATA, 32'd0);
        #1;
        i_rstn = 1'b1;
        tick();

        // Back in LOAD: oversize LOG2N clamps to 12; memory survived reset.
        i_LOG2N = 4'd15;
        i_DATA_LOADED = 1'b1;
        tick();
        i_DATA_LOADED = 1'b0;
        check("post_rst_start", 32'(o_START), 32'd1);
        check("samples_clamped", 32'(o_SAMPLES_NUMBER), 32'hFFF);
        core_read(12'd1, 32'h3001_0000, "mem_kept_a1");
        core_read(12'd3, 32'h2003_0000, "mem_kept_a3");
        core_read(12'd2, 32'hDEAD_BEEF, "mem_kept_a2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_sample_ram.md
# fft_sample_ram

Sample memory and ownership controller between the AXI bridge and the FFT butterfly core. It stores 16-bit real samples written by the bridge in bit-reversed order as 32-bit complex words, hands the memory to the core with a start pulse, and returns results to the bridge in natural order. It also drives the bridge's `i_CALC_END` and `i_SAMPLES_NUMBER` inputs.

## Interface
- `DATA_WIDTH`, 32: complex word width, `{re[31:16], im[15:0]}`.
- `ADDR_WIDTH`, 12: memory address width; depth is 2^ADDR_WIDTH.
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_SAMPLE_ram`  in  16  real sample from the bridge.
- `i_SAMPLE_INDEX_ram`  in  ADDR_WIDTH  bridge sample index.
- `i_WRITE_ram`  in  1  bridge write strobe.
- `i_READ_ram`  in  1  bridge read strobe.
- `i_DATA_LOADED`  in  1  bridge end-of-load pulse.
- `i_LOG2N`  in  4  FFT size exponent; valid values are 1..ADDR_WIDTH.
- `o_DATA_FROM_RAM`  out  DATA_WIDTH  read data to the bridge.
- `o_CALC_END`  out  1  results ready for readout.
- `o_SAMPLES_NUMBER`  out  ADDR_WIDTH  latched N-1.
- `o_START`  out  1  one-cycle pulse to the core.
- `i_CORE_ADDR`  in  ADDR_WIDTH  core address.
- `i_CORE_WE`  in  1  core write enable.
- `i_CORE_WDATA`  in  DATA_WIDTH  core write data.
- `o_CORE_RDATA`  out  DATA_WIDTH  core read data.
- `i_CORE_DONE`  in  1  core finished pulse.
- `o_OVERRUN`  out  1  sticky flag: out-of-range bridge index.

## Operation
- States: LOAD, RUN, UNLOAD. Reset state is LOAD.
- **LOAD**
  - N = 2^i_LOG2N.
  - A bridge write with index < N stores `{i_SAMPLE_ram, 16'h0}` at bitrev(index).
  - bitrev(index) reverses the low i_LOG2N bits; upper address bits are 0.
  - A bridge write with index ≥ N is dropped and sets `o_OVERRUN`.
  - Bridge reads and all core accesses are ignored.
  - `i_DATA_LOADED`: latch i_LOG2N, set `o_SAMPLES_NUMBER` = N-1, pulse `o_START`, go to RUN.
- **RUN**
  - The core owns the memory: `i_CORE_ADDR`, `i_CORE_WE`, `i_CORE_WDATA` drive it.
  - Bridge strobes are ignored.
  - `i_CORE_DONE` → UNLOAD; `o_CALC_END` is set and held.
- **UNLOAD**
  - Each bridge read fetches the natural-order address `i_SAMPLE_INDEX_ram`.
  - Bridge writes and core accesses are ignored.
  - A read of index N-1 → LOAD: `o_CALC_END` clears and `o_OVERRUN` clears.
- Simultaneous `i_WRITE_ram` and `i_DATA_LOADED` in LOAD: the write is stored first, then the transition takes effect.
- `i_CORE_DONE` outside RUN is ignored. `i_DATA_LOADED` outside LOAD is ignored.
- i_LOG2N of 0 is treated as 1. Values above ADDR_WIDTH are treated as ADDR_WIDTH.
- Memory contents are never cleared by reset.

## Timing
- Reset values:
  - `o_START` = 0, `o_CALC_END` = 0, `o_OVERRUN` = 0.
  - `o_SAMPLES_NUMBER` = 0.
  - `o_DATA_FROM_RAM` = 0, `o_CORE_RDATA` = 0.
- Writes commit on the strobe's clock edge.
- Read latency is 1 cycle: data appears the cycle after a strobe or address and is held until the next read.
- `o_START` is high for exactly the cycle after `i_DATA_LOADED` is sampled.
- `o_CALC_END` rises the cycle after `i_CORE_DONE`.
- `o_CALC_END` falls the cycle after the final read strobe. Read data for that index is still delivered that cycle.
- Reset asserted mid-RUN or mid-UNLOAD: immediately go to LOAD, all outputs return to reset values, and a pending start is lost.

## Structure
- Package `fft_ram_pkg` holds:
  - enum `ram_state {RAM_LOAD, RAM_RUN, RAM_UNLOAD}`;
  - function `bitrev(index, log2n)`;
  - localparam for the imaginary zero pad.
- Sub-module `sample_mem`: single-port synchronous RAM, 2^ADDR_WIDTH × DATA_WIDTH, with registered read. Its port mux is owned by the top-level FSM.

## Test plan
- Bit-reverse load: i_LOG2N=3; write samples 0x1000+i at indices i=0..7; `i_DATA_LOADED`. Expect:
  - `o_START` is a single pulse;
  - core reads address 1 → 0x1004_0000;
  - core reads address 3 → 0x1006_0000.
- Overrun: i_LOG2N=2; write index 5. Expect:
  - nothing is stored;
  - `o_OVERRUN`=1 next cycle;
  - `o_OVERRUN` clears after a full UNLOAD.
- Handover: core writes 0xDEAD_BEEF at address 2, then `i_CORE_DONE`. Expect:
  - `o_CALC_END`=1 next cycle;
  - bridge read of index 2 → 0xDEAD_BEEF one cycle later.
- Ownership: bridge write in RUN and core write in UNLOAD. Expect memory unchanged, checked by readback.
- Readout exit: i_LOG2N=3; bridge reads indices 0..7. Expect:
  - `o_SAMPLES_NUMBER`=7 throughout;
  - `o_CALC_END` falls after index 7;
  - state returns to LOAD.
- Reset mid-RUN: assert `i_rstn`=0. Expect all outputs 0 and LOAD state; previously loaded memory data is intact on the next readback.
